// File: rtl/silu_result_packer.sv
// silu_result_packer: pairs BF16 SiLU results into 32-bit words behind a credit-guarded show-ahead FIFO
module silu_result_packer #(
  parameter int DEPTH    = 4,
  parameter int PIPE_LAT = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue,
  output logic        issue_ok,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_mask,
  output logic        err
);
  localparam int CW = $clog2(2*DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH+1);
  if (DEPTH < 2 || (DEPTH & (DEPTH-1)) != 0 || PIPE_LAT < 0) begin : g_bad_param
    $error("silu_result_packer: DEPTH must be a power of two >= 2 and PIPE_LAT >= 0");
  end
  logic [CW-1:0] credits, credits_next;
  logic [CW+1:0] gross;
  logic [15:0]   pend;
  logic          pend_flag, flush_req;
  logic [33:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count;
  logic          pop, pad, wr, wr_ok, full;
  logic [33:0]   wdata;
  always_comb begin
    out_valid    = count != '0;
    pop          = out_valid & out_ready;
    full         = count == NW'(DEPTH);
    gross        = (CW+2)'(credits) + (pop ? (CW+2)'(2) : '0);
    // a pad only commits when the slot it claims is covered by this cycle's credit
    pad          = flush_req & pend_flag & ~in_valid & (gross > (CW+2)'(issue));
    wr           = (in_valid & pend_flag) | pad;
    wr_ok        = wr & (~full | pop);
    wdata        = pad ? {16'h0000, pend, 2'b01} : {in_data, pend, 2'b11};
    credits_next = gross >= (CW+2)'(issue) + (CW+2)'(pad)
                   ? CW'(gross - (CW+2)'(issue) - (CW+2)'(pad)) : '0;
    issue_ok     = credits != '0;
    out_data     = out_valid ? mem[rd_ptr][33:2] : '0;
    out_mask     = out_valid ? mem[rd_ptr][1:0] : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      credits   <= CW'(2*DEPTH);
      pend      <= '0;
      pend_flag <= 1'b0;
      flush_req <= 1'b0;
      err       <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      credits   <= credits_next;
      err       <= err | (issue & ~issue_ok) | (wr & full & ~pop);
      flush_req <= flush | (flush_req & pend_flag & ~in_valid & ~pad);
      pend_flag <= in_valid ? ~pend_flag : pend_flag & ~pad;
      if (in_valid && !pend_flag) pend <= in_data;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count     <= count + NW'(wr_ok) - NW'(pop);
    end
  end
  always_ff @(posedge clk)
    if (rst && wr_ok) mem[wr_ptr] <= wdata;
endmodule

// File: tb/tb_silu_result_packer.sv
// tb_silu_result_packer: directed checks of pairing, backpressure, flush padding and error flag
module tb_silu_result_packer;
  logic        clk = 0, rst = 0, issue = 0, in_valid = 0, flush = 0, out_ready = 0;
  logic [15:0] in_data = 0;
  logic        issue_ok, out_valid, err;
  logic [31:0] out_data;
  logic [1:0]  out_mask;
  int n_checks = 0, n_fail = 0;

  silu_result_packer #(.DEPTH(4), .PIPE_LAT(7)) dut (
    .clk(clk), .rst(rst), .issue(issue), .issue_ok(issue_ok), .in_valid(in_valid),
    .in_data(in_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mask(out_mask), .err(err));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    issue = 1; in_valid = 1; in_data = d;
    cyc();
    issue = 0; in_valid = 0;
  endtask

  task automatic do_reset();
    rst = 0; out_ready = 0; issue = 0; in_valid = 0; flush = 0;
    cyc();
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    cyc(); cyc();
    rst = 1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    n_checks++; if (out_mask !== 2'b00) begin n_fail++; $display("FAIL reset_out_mask got %b exp 00", out_mask); end
    n_checks++; if (issue_ok !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ok got %b exp 1", issue_ok); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
    n_checks++; if (dut.credits !== 4'd8) begin n_fail++; $display("FAIL reset_credits got %0d exp 8", dut.credits); end
  endtask

  task automatic test_pairing();
    out_ready = 1;
    push(16'h3F80);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pair_half_no_write got %b exp 0", out_valid); end
    n_checks++; if (dut.credits !== 4'd7) begin n_fail++; $display("FAIL pair_credits_7 got %0d exp 7", dut.credits); end
    push(16'h4000);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pair_valid got %b exp 1", out_valid); end
    n_checks++; if (out_data !== 32'h40003F80) begin n_fail++; $display("FAIL pair_data got %h exp 40003f80", out_data); end
    n_checks++; if (out_mask !== 2'b11) begin n_fail++; $display("FAIL pair_mask got %b exp 11", out_mask); end
    n_checks++; if (dut.credits !== 4'd6) begin n_fail++; $display("FAIL pair_credits_6 got %0d exp 6", dut.credits); end
    cyc();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pair_drained got %b exp 0", out_valid); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL pair_data_zero got %h exp 0", out_data); end
    n_checks++; if (dut.credits !== 4'd8) begin n_fail++; $display("FAIL pair_credits_back got %0d exp 8", dut.credits); end
    out_ready = 0;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_w [4] = '{32'h10011000, 32'h10031002, 32'h10051004, 32'h10071006};
    out_ready = 0;
    for (int i = 0; i < 8; i++) push(16'h1000 + 16'(i));
    n_checks++; if (issue_ok !== 1'b0) begin n_fail++; $display("FAIL bp_issue_ok_low got %b exp 0", issue_ok); end
    n_checks++; if (dut.count !== 3'd4) begin n_fail++; $display("FAIL bp_count got %0d exp 4", dut.count); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL bp_err got %b exp 0", err); end
    n_checks++; if (out_data !== exp_w[0]) begin n_fail++; $display("FAIL bp_word0 got %h exp %h", out_data, exp_w[0]); end
    out_ready = 1;
    for (int k = 1; k < 4; k++) begin
      cyc();
      if (k == 1) begin
        n_checks++; if (issue_ok !== 1'b1) begin n_fail++; $display("FAIL bp_issue_ok_after_pop got %b exp 1", issue_ok); end
      end
      n_checks++; if (out_data !== exp_w[k] || out_mask !== 2'b11) begin n_fail++; $display("FAIL bp_word%0d got %h/%b exp %h/11", k, out_data, out_mask, exp_w[k]); end
    end
    cyc();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b exp 0", out_valid); end
    n_checks++; if (dut.credits !== 4'd8) begin n_fail++; $display("FAIL bp_credits got %0d exp 8", dut.credits); end
    out_ready = 0;
  endtask

  task automatic test_odd_flush();
    out_ready = 0;
    push(16'h1111); push(16'h2222); push(16'h3333);
    flush = 1;
    cyc();
    flush = 0;
    cyc();
    n_checks++; if (out_data !== 32'h22221111 || out_mask !== 2'b11) begin n_fail++; $display("FAIL odd_word0 got %h/%b exp 22221111/11", out_data, out_mask); end
    n_checks++; if (dut.count !== 3'd2) begin n_fail++; $display("FAIL odd_count got %0d exp 2", dut.count); end
    n_checks++; if (dut.credits !== 4'd4) begin n_fail++; $display("FAIL odd_credits_pad got %0d exp 4", dut.credits); end
    n_checks++; if (dut.flush_req !== 1'b0) begin n_fail++; $display("FAIL odd_flush_req got %b exp 0", dut.flush_req); end
    out_ready = 1;
    cyc();
    n_checks++; if (out_data !== 32'h00003333 || out_mask !== 2'b01) begin n_fail++; $display("FAIL odd_pad_word got %h/%b exp 00003333/01", out_data, out_mask); end
    cyc();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL odd_empty got %b exp 0", out_valid); end
    n_checks++; if (dut.credits !== 4'd8) begin n_fail++; $display("FAIL odd_credits_end got %0d exp 8", dut.credits); end
    out_ready = 0;
  endtask

  task automatic test_deferred_flush();
    do_reset();
    for (int i = 0; i < 7; i++) push(16'hA000 + 16'(i));
    issue = 1;
    cyc();
    issue = 0;
    n_checks++; if (issue_ok !== 1'b0 || dut.credits !== 4'd0) begin n_fail++; $display("FAIL def_credits_zero got %b/%0d exp 0/0", issue_ok, dut.credits); end
    flush = 1;
    cyc();
    flush = 0;
    cyc(); cyc();
    n_checks++; if (dut.count !== 3'd3 || dut.flush_req !== 1'b1) begin n_fail++; $display("FAIL def_no_write got %0d/%b exp 3/1", dut.count, dut.flush_req); end
    out_ready = 1;
    cyc();
    out_ready = 0;
    n_checks++; if (dut.count !== 3'd3 || dut.flush_req !== 1'b0) begin n_fail++; $display("FAIL def_pad_on_pop got %0d/%b exp 3/0", dut.count, dut.flush_req); end
    n_checks++; if (dut.credits !== 4'd1) begin n_fail++; $display("FAIL def_credits_1 got %0d exp 1", dut.credits); end
    n_checks++; if (out_data !== 32'hA003A002) begin n_fail++; $display("FAIL def_head got %h exp a003a002", out_data); end
    in_valid = 1; in_data = 16'hA007;
    cyc();
    in_valid = 0;
    out_ready = 1;
    cyc();
    n_checks++; if (out_data !== 32'hA005A004 || out_mask !== 2'b11) begin n_fail++; $display("FAIL def_word2 got %h/%b exp a005a004/11", out_data, out_mask); end
    cyc();
    n_checks++; if (out_data !== 32'h0000A006 || out_mask !== 2'b01) begin n_fail++; $display("FAIL def_pad_word got %h/%b exp 0000a006/01", out_data, out_mask); end
    cyc();
    n_checks++; if (out_valid !== 1'b0 || dut.credits !== 4'd7) begin n_fail++; $display("FAIL def_end got %b/%0d exp 0/7", out_valid, dut.credits); end
    do_reset();
    for (int i = 0; i < 7; i++) push(16'hB000 + 16'(i));
    issue = 1;
    cyc();
    issue = 0; flush = 1;
    cyc();
    flush = 0;
    cyc();
    n_checks++; if (dut.flush_req !== 1'b1) begin n_fail++; $display("FAIL cmp_flush_pending got %b exp 1", dut.flush_req); end
    in_valid = 1; in_data = 16'hB007;
    cyc();
    in_valid = 0;
    cyc();
    n_checks++; if (dut.count !== 3'd4 || dut.flush_req !== 1'b0) begin n_fail++; $display("FAIL cmp_no_pad got %0d/%b exp 4/0", dut.count, dut.flush_req); end
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (out_data !== {16'hB001 + 16'(2*k), 16'hB000 + 16'(2*k)} || out_mask !== 2'b11) begin n_fail++; $display("FAIL cmp_word%0d got %h/%b", k, out_data, out_mask); end
      cyc();
    end
    n_checks++; if (out_valid !== 1'b0 || dut.credits !== 4'd8) begin n_fail++; $display("FAIL cmp_end got %b/%0d exp 0/8", out_valid, dut.credits); end
    out_ready = 0;
  endtask

  task automatic test_err();
    do_reset();
    for (int i = 0; i < 8; i++) push(16'hC000 + 16'(i));
    n_checks++; if (err !== 1'b0 || issue_ok !== 1'b0) begin n_fail++; $display("FAIL err_pre got %b/%b exp 0/0", err, issue_ok); end
    issue = 1;
    cyc();
    issue = 0;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set got %b exp 1", err); end
    n_checks++; if (dut.credits !== 4'd0) begin n_fail++; $display("FAIL err_saturate got %0d exp 0", dut.credits); end
    cyc(); cyc();
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b exp 1", err); end
    do_reset();
    n_checks++; if (err !== 1'b0 || issue_ok !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL err_cleared got %b/%b/%b exp 0/1/0", err, issue_ok, out_valid); end
  endtask

  initial begin
    test_reset();
    test_pairing();
    test_backpressure();
    test_odd_flush();
    test_deferred_flush();
    test_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
